ws2812_frame_ctl: RTL
=====================

Name: ws2812_frame_ctl

Overview:
- Frame-level sequencer for the WS2812 single-bit encoder. It fetches 24-bit GRB pixel words from a pixel RAM and serializes them MSB first.
- For each bit it hands the encoder a bit_rdy/bit_data pair, then waits for the encoder's bit_done pulse.
- After the last pixel it holds the line idle for a latch (reset) gap, then reports frame completion.
- Sits between the host/config logic that owns the pixel RAM and the bit encoder.

Parameters:
- ADDR_WIDTH, 8, width of pixel RAM address and LED count.
- CNT_LATCH, 16'd12000, latch-gap length in clk_in cycles (60 us at 200 MHz; must exceed 50 us).
- CNT_TIMEOUT, 16'd1000, max cycles to wait for bit_done_in before aborting the frame.

Ports:
- clk_in  in  1  clock, 200 MHz.
- rst_n_in  in  1  reset, asynchronous, active-low.
- frame_start_in  in  1  start pulse; sampled only in IDLE.
- led_num_in  in  ADDR_WIDTH  number of pixels in frame; latched at start.
- ram_rd_en_out  out  1  pixel RAM read strobe, one cycle.
- ram_rd_addr_out  out  ADDR_WIDTH  pixel index.
- ram_rd_data_in  in  24  GRB word, valid exactly 1 cycle after ram_rd_en_out.
- bit_rdy_out  out  1  one-cycle request to the encoder.
- bit_data_out  out  1  current bit; stable from bit_rdy_out until bit_done_in.
- bit_done_in  in  1  one-cycle pulse from the encoder when its bit period ends.
- frame_busy_out  out  1  high from accepted start until frame_done_out.
- frame_done_out  out  1  one-cycle pulse at end of latch gap.
- frame_err_out  out  1  sticky timeout flag; cleared on the next accepted start.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, latched count 0. Async reset mid-frame aborts immediately with no done pulse.
- All outputs are registered.
- State IDLE:
  - On frame_start_in=1: latch led_num_in, set pix=0, set frame_busy_out=1, clear frame_err_out.
  - Go to LATCH if the count is 0, else to READ.
- State READ: ram_rd_en_out=1 for one cycle, ram_rd_addr_out=pix -> CAPTURE.
- State CAPTURE: load the shift register from ram_rd_data_in, bit_idx=23 -> ISSUE.
- State ISSUE:
  - bit_rdy_out=1 for exactly one cycle; bit_data_out=shift[23] (reg, held).
  - Clear timeout counter -> WAIT.
- State WAIT:
  - On bit_done_in: shift left by 1.
    - If bit_idx≠0: bit_idx-1 -> ISSUE.
    - Else if pix≠count-1: pix+1 -> READ.
    - Else -> LATCH.
  - Timeout counter increments each cycle. On reaching CNT_TIMEOUT without bit_done_in: set frame_err_out=1 -> LATCH (frame truncated).
- State LATCH:
  - bit_data_out=0; counter 0..CNT_LATCH-1.
  - At CNT_LATCH-1: frame_done_out=1 for 1 cycle, frame_busy_out=0 -> IDLE.
- Latency:
  - Start sampled in cycle 0 -> ram_rd_en_out in cycle 1 -> first bit_rdy_out in cycle 3.
  - bit_done_in (non-final bit of a pixel) in cycle t -> next bit_rdy_out in cycle t+2.
  - Last bit of a pixel done in cycle t -> ram_rd_en_out in cycle t+1 -> bit_rdy_out in cycle t+3.
- Ignored inputs:
  - frame_start_in outside IDLE.
  - bit_done_in outside WAIT.
  - Changes to led_num_in after start.
- Simultaneous events:
  - frame_start_in in the same cycle frame_done_out is asserted is ignored (state is LATCH).
  - bit_done_in in the cycle the timeout is reached: done wins, no error.
- Wrap-around:
  - Maximum count 2^ADDR_WIDTH-1 pixels.
  - pix never wraps, because the compare against count-1 precedes the increment.
- Bit order: G[7]..G[0], R[7]..R[0], B[7]..B[0]; word bit 23 is sent first.

Test Plan:
- Single pixel: led_num=1, RAM[0]=24'hA50F3C, encoder model returns bit_done 20 cycles after each bit_rdy.
  - Required: exactly 24 bit_rdy pulses with bits 101001010000111100111100.
  - Required: one read at addr 0.
  - Required: frame_done exactly CNT_LATCH cycles after the final LATCH entry; frame_busy is 0 afterwards.
- Multi-pixel: led_num=3, RAM = 24'hFFFFFF, 24'h000000, 24'h800001.
  - Required: reads at addr 0, 1, 2 in order.
  - Required: 72 bits matching, last pixel sent as 1, 22×0, then 1.
  - Required: first bit_rdy 3 cycles after start.
- Zero length: led_num=0 -> no ram_rd_en, no bit_rdy; frame_done after CNT_LATCH cycles.
- Timeout: encoder model drops bit_done after bit 5.
  - Required: frame_err=1 after CNT_TIMEOUT cycles, then the latch gap and frame_done.
  - Required: next start clears frame_err.
- Ignored inputs: frame_start pulses and led_num changes mid-frame, plus a spurious bit_done in ISSUE/READ.
  - Required: bit stream and pixel count unchanged.
- Reset mid-frame: deassert rst_n_in during bit 10 of pixel 1.
  - Required: all outputs 0 immediately; IDLE; a clean frame on the next start.

Source files
------------

// File: rtl/ws2812_frame_ctl.sv
// Frame sequencer for the WS2812 bit encoder: fetches 24-bit GRB words from pixel RAM,
// hands them to the encoder one bit at a time (MSB first), then holds a latch gap.
`timescale 1ns/1ps

// state     | meaning
// S_IDLE    | waiting for frame_start_in; outputs quiet except sticky error
// S_READ    | ram_rd_en_out high this cycle for pixel r_pix
// S_CAPTURE | RAM word valid; load shifter and raise the first bit_rdy
// S_ISSUE   | raise bit_rdy for the next bit of the current word
// S_WAIT    | waiting for bit_done_in, timeout counter running
// S_LATCH   | line held low for the latch gap; frame_done at its end
module ws2812_frame_ctl #(
  parameter int          ADDR_WIDTH  = 8,
  parameter logic [15:0] CNT_LATCH   = 16'd12000,
  parameter logic [15:0] CNT_TIMEOUT = 16'd1000
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  frame_start_in,
  input  logic [ADDR_WIDTH-1:0] led_num_in,
  output logic                  ram_rd_en_out,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr_out,
  input  logic [23:0]           ram_rd_data_in,
  output logic                  bit_rdy_out,
  output logic                  bit_data_out,
  input  logic                  bit_done_in,
  output logic                  frame_busy_out,
  output logic                  frame_done_out,
  output logic                  frame_err_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_ISSUE,
    S_WAIT,
    S_LATCH
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_count;
  logic [ADDR_WIDTH-1:0] r_pix;
  logic [23:0]           r_shift;
  logic [4:0]            r_bit_idx;
  logic [15:0]           r_tmo_cnt;
  logic [15:0]           r_lat_cnt;

  logic                  r_ram_rd_en;
  logic [ADDR_WIDTH-1:0] r_ram_rd_addr;
  logic                  r_bit_rdy;
  logic                  r_bit_data;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic w_last_pix;
  logic w_tmo_hit;
  logic w_lat_pre;
  logic w_lat_end;

  // Compare before increment, so r_pix never wraps even at the maximum count.
  assign w_last_pix = (r_pix == r_count - ADDR_WIDTH'(1));
  assign w_tmo_hit  = (r_tmo_cnt == CNT_TIMEOUT - 16'd1);
  // frame_done is raised during the final LATCH cycle; CNT_LATCH must be >= 2.
  assign w_lat_pre  = (r_lat_cnt == CNT_LATCH - 16'd2);
  assign w_lat_end  = (r_lat_cnt == CNT_LATCH - 16'd1);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_pix         <= '0;
      r_shift       <= '0;
      r_bit_idx     <= '0;
      r_tmo_cnt     <= '0;
      r_lat_cnt     <= '0;
      r_ram_rd_en   <= 1'b0;
      r_ram_rd_addr <= '0;
      r_bit_rdy     <= 1'b0;
      r_bit_data    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_ram_rd_en <= 1'b0;
      r_bit_rdy   <= 1'b0;
      r_done      <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (frame_start_in) begin
            r_count    <= led_num_in;
            r_pix      <= '0;
            r_busy     <= 1'b1;
            r_err      <= 1'b0;
            r_bit_data <= 1'b0;
            if (led_num_in == '0) begin
              r_lat_cnt <= '0;
              r_state   <= S_LATCH;
            end else begin
              r_ram_rd_en   <= 1'b1;
              r_ram_rd_addr <= '0;
              r_state       <= S_READ;
            end
          end
        end

        S_READ: begin
          r_state <= S_CAPTURE;
        end

        S_CAPTURE: begin
          r_shift    <= ram_rd_data_in;
          r_bit_idx  <= 5'd23;
          r_bit_rdy  <= 1'b1;
          r_bit_data <= ram_rd_data_in[23];
          r_tmo_cnt  <= '0;
          r_state    <= S_WAIT;
        end

        S_ISSUE: begin
          r_bit_rdy  <= 1'b1;
          r_bit_data <= r_shift[23];
          r_tmo_cnt  <= '0;
          r_state    <= S_WAIT;
        end

        S_WAIT: begin
          // A done arriving on the timeout cycle still counts as a normal bit.
          if (bit_done_in) begin
            r_shift <= {r_shift[22:0], 1'b0};
            if (r_bit_idx != 5'd0) begin
              r_bit_idx <= r_bit_idx - 5'd1;
              r_state   <= S_ISSUE;
            end else if (!w_last_pix) begin
              r_pix         <= r_pix + ADDR_WIDTH'(1);
              r_ram_rd_en   <= 1'b1;
              r_ram_rd_addr <= r_pix + ADDR_WIDTH'(1);
              r_state       <= S_READ;
            end else begin
              r_bit_data <= 1'b0;
              r_lat_cnt  <= '0;
              r_state    <= S_LATCH;
            end
          end else if (w_tmo_hit) begin
            r_err      <= 1'b1;
            r_bit_data <= 1'b0;
            r_lat_cnt  <= '0;
            r_state    <= S_LATCH;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
          end
        end

        S_LATCH: begin
          r_bit_data <= 1'b0;
          if (w_lat_end) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_done    <= w_lat_pre;
            r_lat_cnt <= r_lat_cnt + 16'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ram_rd_en_out   = r_ram_rd_en;
  assign ram_rd_addr_out = r_ram_rd_addr;
  assign bit_rdy_out     = r_bit_rdy;
  assign bit_data_out    = r_bit_data;
  assign frame_busy_out  = r_busy;
  assign frame_done_out  = r_done;
  assign frame_err_out   = r_err;

endmodule
